sysclk_nibble_tx: RTL and testbench
===================================

Name: sysclk_nibble_tx

Overview:
- SYSCLK-domain transmitter for the 4-bit TURFIO→TURF nibble link, feeding the inbound 4-bit path that the TURF-side rxclk/sysclk capture logic receives.
- Serialises 32-bit words, MSB nibble first, into fixed-length slots.
- While `train_i` is high it sends a repeating training word so the far end can align its clock and nibble phase.
- When training is released it sends header-tagged data or idle slots, with a valid/ready handshake to the upstream word source.

Parameters:
- TRAIN_PATTERN, 32'hA55A6996, word repeated in every TRAIN slot.
- IDLE_WORD, 32'h00000000, payload of an idle RUN slot.
- HDR_DATA, 4'hD, header nibble of a RUN slot that carries a data word.
- HDR_IDLE, 4'h5, header nibble of a RUN slot that carries IDLE_WORD.

Ports:
- sysclk_i  in  1  system clock; all logic is in this domain.
- rst_i  in  1  synchronous, active-high reset.
- train_i  in  1  level request for training mode; sampled only at slot boundaries.
- s_tdata_i  in  32  word to transmit.
- s_tvalid_i  in  1  s_tdata_i is valid.
- s_tready_o  out  1  word accepted on this edge when s_tvalid_i is also high.
- data_o  out  4  registered link nibble.
- running_o  out  1  high while RUN slots are being transmitted.
- word_count_o  out  32  count of accepted data words; wraps at 2^32.

Behaviour:
- **Registers:** mode (TRAIN/RUN), phase counter (4 bits), 32-bit payload shift register, header register, word counter.
- **Reset (rst_i high at an edge):**
  - data_o <= 0, running_o <= 0, word_count_o <= 0.
  - mode <= TRAIN, phase <= 0, payload <= TRAIN_PATTERN.
  - s_tready_o = 0 while rst_i is high (combinational gating).
- **Slot lengths:** a TRAIN slot is 8 nibbles (phases 0..7). A RUN slot is 9 nibbles: phase 0 is the header, phases 1..8 are the payload.
- **Nibble order:** payload nibbles go out MSB first, so TRAIN phase k emits payload[31-4k -: 4].
- **Latency:** data_o is registered. The first edge with rst_i low drives data_o = TRAIN_PATTERN[31:28] (4'hA); phase 1 follows on the next edge, and so on.
- **Slot boundary:** the last phase is 7 in TRAIN and 8 in RUN. On the edge that emits the last nibble:
  - next mode <= train_i ? TRAIN : RUN.
  - phase <= 0.
  - Next payload is loaded according to the next mode.
- **Next-payload selection:**
  - Next mode TRAIN: payload <= TRAIN_PATTERN.
  - Next mode RUN with handshake: payload <= s_tdata_i, header <= HDR_DATA, word_count_o increments.
  - Next mode RUN without handshake: payload <= IDLE_WORD, header <= HDR_IDLE.
- **Handshake rules:**
  - s_tready_o = (phase == last phase of current mode) && !train_i && !rst_i.
  - Therefore s_tready_o is high for exactly one cycle per slot, and never when the next slot is TRAIN.
  - A word is transferred only when s_tvalid_i && s_tready_o at an edge.
  - s_tvalid_i may assert or drop freely; there is no obligation on the source to hold.
- **running_o:** registered; <= 1 on the edge that begins a RUN slot, <= 0 on the edge that begins a TRAIN slot. It therefore changes together with the first nibble of the new slot.
- **Mode changes:** train_i edges mid-slot have no effect until the slot boundary; the current slot always completes.
  - TRAIN→RUN: the first RUN nibble is a header, on the edge after phase 7.
  - RUN→TRAIN: the last RUN payload nibble is followed directly by TRAIN_PATTERN[31:28].
- **Word counter:** 32-bit; 32'hFFFFFFFF + 1 = 0 with no flag.
- **Reset mid-slot:** the slot is abandoned, and data_o shows 0 on the reset edge. A word already accepted but not fully sent is dropped; word_count_o is cleared anyway. Training restarts at phase 0 after reset releases.
- **Phase counter:** never exceeds 8; an illegal value (from an upset) is treated as the last phase and resynchronises at the next edge.

Test Plan:
1. **Training pattern:** release rst_i with train_i=1 → data_o sequence A,5,5,A,6,9,9,6 repeating; s_tready_o stays 0; running_o = 0.
2. **Idle slots:** drop train_i mid-slot at phase 3 → current TRAIN slot completes, then nibble stream 5,0,0,0,0,0,0,0,0 repeats. running_o rises with the first 5. word_count_o = 0.
3. **Back-to-back data:** hold s_tvalid_i=1 with s_tdata_i=32'h12345678 then 32'h9ABCDEF0 → slots D,1,2,3,4,5,6,7,8 then D,9,A,B,C,D,E,F,0. s_tready_o pulses once per 9 cycles; word_count_o = 2.
4. **Late valid:** assert s_tvalid_i one cycle after s_tready_o pulses → that slot is idle (5 header). The word is taken at the next boundary, sent in the following slot, and word_count_o increments only then.
5. **Return to training:** raise train_i during RUN phase 4 while s_tvalid_i=1 → current slot finishes; s_tready_o stays low at the boundary (word not taken); next nibble is A; running_o falls on that edge.
6. **Reset and counter wrap:**
   - Pulse rst_i at RUN phase 5 → data_o = 0 on the reset edge, counters cleared, training restarts with A.
   - Force word_count_o to 32'hFFFFFFFF and accept one word → counter reads 0.

Source files
------------

// File: rtl/sysclk_nibble_tx.sv
// sysclk_nibble_tx: SYSCLK-domain serialiser for the 4-bit TURFIO->TURF link.
// Sends 32-bit words MSB nibble first in fixed slots. TRAIN slots (8 nibbles)
// repeat a training word. RUN slots (9 nibbles) send a header nibble and then
// either an accepted data word or an idle word.
module sysclk_nibble_tx #(
  parameter logic [31:0] TRAIN_PATTERN = 32'hA55A6996,
  parameter logic [31:0] IDLE_WORD     = 32'h00000000,
  parameter logic [3:0]  HDR_DATA      = 4'hD,
  parameter logic [3:0]  HDR_IDLE      = 4'h5
) (
  input  logic        sysclk_i,
  input  logic        rst_i,
  input  logic        train_i,
  input  logic [31:0] s_tdata_i,
  input  logic        s_tvalid_i,
  output logic        s_tready_o,
  output logic [3:0]  data_o,
  output logic        running_o,
  output logic [31:0] word_count_o
);

  localparam logic [0:0] MODE_TRAIN = 1'b0;
  localparam logic [0:0] MODE_RUN   = 1'b1;

  logic [0:0]  mode_q, mode_d;
  logic [3:0]  phase_q, phase_d;
  logic [31:0] payload_q, payload_d;
  logic [3:0]  header_q, header_d;
  logic [31:0] word_count_q, word_count_d;
  logic [3:0]  data_q, data_d;
  logic        running_q, running_d;
  logic        is_last;
  logic        accept;

  // Slot-boundary detection and the one-cycle-per-slot ready pulse; any phase
  // at or beyond the last legal value counts as the boundary so an upset
  // phase resynchronises on the next edge.
  always_comb begin
    is_last    = (mode_q == MODE_TRAIN) ? (phase_q >= 4'd7) : (phase_q >= 4'd8);
    s_tready_o = is_last && !train_i && !rst_i;
    accept     = s_tready_o && s_tvalid_i;
  end

  // Next-state logic: emit one nibble per edge and reload at slot boundaries.
  always_comb begin
    mode_d       = mode_q;
    phase_d      = phase_q;
    payload_d    = payload_q;
    header_d     = header_q;
    word_count_d = word_count_q;
    running_d    = (mode_q == MODE_RUN);
    if (mode_q == MODE_RUN && phase_q == 4'd0) begin
      data_d = header_q;
    end else begin
      data_d    = payload_q[31:28];
      payload_d = {payload_q[27:0], 4'h0};
    end
    if (is_last) begin
      phase_d = 4'd0;
      if (train_i) begin
        mode_d    = MODE_TRAIN;
        payload_d = TRAIN_PATTERN;
      end else if (accept) begin
        mode_d       = MODE_RUN;
        payload_d    = s_tdata_i;
        header_d     = HDR_DATA;
        word_count_d = word_count_q + 32'd1;
      end else begin
        mode_d    = MODE_RUN;
        payload_d = IDLE_WORD;
        header_d  = HDR_IDLE;
      end
    end else begin
      phase_d = phase_q + 4'd1;
    end
  end

  // State registers with synchronous reset back into training at phase 0.
  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      mode_q       <= MODE_TRAIN;
      phase_q      <= 4'd0;
      payload_q    <= TRAIN_PATTERN;
      header_q     <= HDR_IDLE;
      word_count_q <= 32'd0;
      data_q       <= 4'h0;
      running_q    <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      phase_q      <= phase_d;
      payload_q    <= payload_d;
      header_q     <= header_d;
      word_count_q <= word_count_d;
      data_q       <= data_d;
      running_q    <= running_d;
    end
  end

  assign data_o       = data_q;
  assign running_o    = running_q;
  assign word_count_o = word_count_q;

endmodule

// File: tb/tb_sysclk_nibble_tx.sv
// Bench for sysclk_nibble_tx: a slot-level scoreboard queues the expected
// nibble stream whenever a slot is decided; each edge pops and compares.
module tb_sysclk_nibble_tx;

  localparam logic [31:0] TRAIN_PATTERN = 32'hA55A6996;

  logic        sysclk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        train_i = 1'b1;
  logic [31:0] s_tdata_i = 32'h0;
  logic        s_tvalid_i = 1'b0;
  logic        s_tready_o;
  logic [3:0]  data_o;
  logic        running_o;
  logic [31:0] word_count_o;

  sysclk_nibble_tx dut (
    .sysclk_i(sysclk_i), .rst_i(rst_i), .train_i(train_i),
    .s_tdata_i(s_tdata_i), .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o),
    .data_o(data_o), .running_o(running_o), .word_count_o(word_count_o)
  );

  // Free-running 10 ns system clock.
  always #5 sysclk_i = ~sysclk_i;

  typedef struct {
    logic [3:0] nib;
    logic       run;
  } exp_t;

  typedef struct {
    logic       train;
    logic       valid;
    logic [31:0] data;
    logic [3:0] exp_nib;
    logic       exp_ready;
    logic       exp_run;
  } vec_t;

  exp_t        sb[$];
  logic [31:0] exp_count = 32'h0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [3:0]  last_data;
  logic        last_run;
  logic        last_ready;
  logic        last_acc;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_train();
    logic [31:0] w;
    w = TRAIN_PATTERN;
    for (int k = 0; k < 8; k++) sb.push_back('{nib: w[31-4*k -: 4], run: 1'b0});
  endtask

  task automatic push_run(input logic [3:0] hdr, input logic [31:0] word);
    sb.push_back('{nib: hdr, run: 1'b1});
    for (int k = 0; k < 8; k++) sb.push_back('{nib: word[31-4*k -: 4], run: 1'b1});
  endtask

  // One clock cycle: drive inputs, check ready, decide next slot, check outputs.
  task automatic applyStimulus(input logic train, input logic valid, input logic [31:0] data);
    logic boundary;
    exp_t e;
    @(negedge sysclk_i);
    rst_i = 1'b0;
    train_i = train;
    s_tvalid_i = valid;
    s_tdata_i = data;
    #1;
    boundary = (sb.size() == 1);
    checkOutput("ready", {31'h0, s_tready_o}, {31'h0, boundary && !train});
    last_ready = s_tready_o;
    last_acc = boundary && !train && valid;
    if (boundary) begin
      if (train) push_train();
      else if (valid) begin
        push_run(4'hD, data);
        exp_count = exp_count + 32'd1;
      end else push_run(4'h5, 32'h0);
    end
    @(posedge sysclk_i);
    #1;
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      checkOutput("data_o", {28'h0, data_o}, {28'h0, e.nib});
      checkOutput("running_o", {31'h0, running_o}, {31'h0, e.run});
    end
    checkOutput("word_count_o", word_count_o, exp_count);
    last_data = data_o;
    last_run = running_o;
  endtask

  // Reset edge with valid high: ready gated, outputs cleared, training queued.
  task automatic do_reset();
    @(negedge sysclk_i);
    rst_i = 1'b1;
    train_i = 1'b0;
    s_tvalid_i = 1'b1;
    #1;
    checkOutput("ready_in_reset", {31'h0, s_tready_o}, 32'h0);
    @(posedge sysclk_i);
    #1;
    checkOutput("reset_data", {28'h0, data_o}, 32'h0);
    checkOutput("reset_running", {31'h0, running_o}, 32'h0);
    checkOutput("reset_count", word_count_o, 32'h0);
    sb.delete();
    push_train();
    exp_count = 32'h0;
  endtask

  initial begin
    vec_t        tbl[16];
    logic [3:0]  train_seq[8];
    logic [31:0] wq[$];
    logic        found;

    train_seq = '{4'hA, 4'h5, 4'h5, 4'hA, 4'h6, 4'h9, 4'h9, 4'h6};
    for (int i = 0; i < 16; i++)
      tbl[i] = '{train: 1'b1, valid: (i % 3 == 0), data: 32'hDEAD0000 + i,
                 exp_nib: train_seq[i % 8], exp_ready: 1'b0, exp_run: 1'b0};

    do_reset();

    // Training pattern from the table, with valid toggling and never taken.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(tbl[i].train, tbl[i].valid, tbl[i].data);
      checkOutput("tbl_data", {28'h0, last_data}, {28'h0, tbl[i].exp_nib});
      checkOutput("tbl_ready", {31'h0, last_ready}, {31'h0, tbl[i].exp_ready});
      checkOutput("tbl_run", {31'h0, last_run}, {31'h0, tbl[i].exp_run});
    end

    // Drop train at phase 3: slot completes, then idle slots begin with 5.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("idle_header", {28'h0, last_data}, 32'h5);
    checkOutput("idle_running", {31'h0, last_run}, 32'h1);
    for (int i = 0; i < 17; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("idle_count", word_count_o, 32'h0);

    // Back-to-back data words.
    wq.push_back(32'h12345678);
    wq.push_back(32'h9ABCDEF0);
    for (int i = 0; i < 40 && wq.size() > 0; i++) begin
      applyStimulus(1'b0, 1'b1, wq[0]);
      if (last_acc) void'(wq.pop_front());
    end
    checkOutput("b2b_all_taken", wq.size(), 32'd0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("b2b_count", word_count_o, 32'd2);

    // Late valid: asserted one cycle after the ready pulse.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      found = last_ready;
    end
    checkOutput("late_ready_seen", {31'h0, found}, 32'h1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b0, 1'b1, 32'hCAFEF00D);
      found = last_acc;
      if (!found) checkOutput("late_count_held", word_count_o, 32'd2);
    end
    checkOutput("late_count", word_count_o, 32'd3);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 32'h0);

    // Return to training: raise train at RUN phase 4 with valid high.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h0BADBEEF + i);
      found = (sb.size() == 5) && sb[0].run;
    end
    checkOutput("phase4_reached", {31'h0, found}, 32'h1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 32'h55AA55AA);
    checkOutput("rtt_last_ready", {31'h0, last_ready}, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h55AA55AA);
    checkOutput("rtt_first_nib", {28'h0, last_data}, 32'hA);
    checkOutput("rtt_running", {31'h0, last_run}, 32'h0);

    // Reset at RUN phase 5, then training restarts.
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h00C0FFEE);
      found = (sb.size() == 4) && sb[0].run;
    end
    checkOutput("phase5_reached", {31'h0, found}, 32'h1);
    do_reset();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("post_reset_nib", {28'h0, last_data}, 32'hA);

    // Counter wrap from all-ones on the next accepted word.
    force dut.word_count_q = 32'hFFFFFFFF;
    #1;
    release dut.word_count_q;
    exp_count = 32'hFFFFFFFF;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h0F0F0F0F);
      found = last_acc;
    end
    checkOutput("wrap_count", word_count_o, 32'h0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
